map_sst_seq: RTL and testbench

- Save-state sequencer for the mapper register file (VRC1-class mappers: PRG/CHR bank regs, mirroring bit).
- Walks the mapper SST register space and streams register bytes to the host (save), or streams host bytes back into the mapper registers (load).
- Sits between the host save-state engine and the mapper's sst bus. It is the only driver of sst.act/addr/we_reg/dato while busy.

---
 rtl/map_sst_seq.sv | 202 ++++++++++++++++++++
 tb/tb_map_sst_seq.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/map_sst_seq.sv
`default_nettype none
// ============================================================================
// Module   : map_sst_seq
// Function : Save-state sequencer for the mapper register file. Streams the
//            mapper id and the bank/mirroring registers out to the host
//            (save), or writes a host byte stream back into them (load).
// Revision : 1.0 - initial release
// ============================================================================
module map_sst_seq #(
  parameter int REG_CNT = 6,    // mapper state registers at SST 0..REG_CNT-1
  parameter int ID_ADDR = 127,  // SST address returning the mapper index
  parameter int RD_WAIT = 1,    // cycles from sst_addr change to sst_di sample
  parameter int WE_HOLD = 4     // cycles sst_we_reg is held per write
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_save,
  input  logic       cmd_load,
  input  logic [7:0] map_idx_exp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic       sst_act,
  output logic [7:0] sst_addr,
  output logic       sst_we_reg,
  output logic [7:0] sst_dato,
  input  logic [7:0] sst_di,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready
);

  localparam logic [7:0] C_ID      = 8'(ID_ADDR);
  localparam logic [7:0] C_LAST    = 8'(REG_CNT - 1);
  localparam logic [3:0] C_RD_WAIT = 4'(RD_WAIT);
  // Strobe rises on entry to WR_HOLD, so the count covers WE_HOLD-1 more cycles.
  localparam logic [3:0] C_WE_LOAD = 4'(WE_HOLD - 1);

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_RD_SET  = 4'd1,
    S_RD_CAP  = 4'd2,
    S_RD_PUSH = 4'd3,
    S_LD_WAIT = 4'd4,
    S_LD_CHK  = 4'd5,
    S_WR_HOLD = 4'd6,
    S_WR_GAP  = 4'd7,
    S_FIN     = 4'd8
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_idx;
  logic [7:0] r_byte;
  logic [7:0] r_addr;
  logic [7:0] r_dato;
  logic [7:0] r_out_data;
  logic [3:0] r_cnt;
  logic       r_we;
  logic       r_out_valid;
  logic       r_err;
  logic       r_done;
  logic       r_busy;
  logic       r_act;

  logic w_start_save;
  logic w_start_load;
  logic w_cnt_zero;
  logic w_in_hs;
  logic w_out_hs;
  logic w_idx_last;
  logic w_idx_id;

  // Save wins when both commands arrive together; commands only count in IDLE.
  assign w_start_save = (r_state == S_IDLE) && cmd_save;
  assign w_start_load = (r_state == S_IDLE) && cmd_load && !cmd_save;
  assign w_cnt_zero   = (r_cnt == 4'd0);
  assign w_in_hs      = (r_state == S_LD_WAIT) && in_valid;
  assign w_out_hs     = (r_state == S_RD_PUSH) && out_ready;
  assign w_idx_last   = (r_idx == C_LAST);
  assign w_idx_id     = (r_idx == C_ID);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state decode.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start_save)      w_next = S_RD_SET;
        else if (w_start_load) w_next = S_LD_WAIT;
      end
      S_RD_SET:  w_next = S_RD_CAP;
      S_RD_CAP:  if (w_cnt_zero) w_next = S_RD_PUSH;
      S_RD_PUSH: if (w_out_hs) w_next = w_idx_last ? S_FIN : S_RD_SET;
      S_LD_WAIT: if (w_in_hs) w_next = w_idx_id ? S_LD_CHK : S_WR_HOLD;
      S_LD_CHK:  w_next = (r_byte == map_idx_exp) ? S_LD_WAIT : S_FIN;
      S_WR_HOLD: if (w_cnt_zero) w_next = S_WR_GAP;
      S_WR_GAP:  w_next = w_idx_last ? S_FIN : S_LD_WAIT;
      S_FIN:     w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  // Datapath: index walk, wait counters, sst bus and stream registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= 8'd0;
      r_byte      <= 8'd0;
      r_addr      <= 8'd0;
      r_dato      <= 8'd0;
      r_out_data  <= 8'd0;
      r_cnt       <= 4'd0;
      r_we        <= 1'b0;
      r_out_valid <= 1'b0;
      r_err       <= 1'b0;
      r_done      <= 1'b0;
      r_busy      <= 1'b0;
      r_act       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_start_save || w_start_load) begin
            r_idx  <= C_ID;
            r_err  <= 1'b0;
            r_busy <= 1'b1;
            r_act  <= 1'b1;
          end
        end
        S_RD_SET: begin
          r_addr <= r_idx;
          r_cnt  <= C_RD_WAIT;
        end
        S_RD_CAP: begin
          if (w_cnt_zero) begin
            r_out_data  <= sst_di;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        S_RD_PUSH: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_idx       <= w_idx_id ? 8'd0 : r_idx + 8'd1;
          end
        end
        S_LD_WAIT: begin
          if (w_in_hs) begin
            r_byte <= in_data;
            if (!w_idx_id) begin
              r_addr <= r_idx;
              r_dato <= in_data;
              r_we   <= 1'b1;
              r_cnt  <= C_WE_LOAD;
            end
          end
        end
        S_LD_CHK: begin
          // A wrong mapper id aborts before any register is touched.
          if (r_byte == map_idx_exp) r_idx <= 8'd0;
          else                       r_err <= 1'b1;
        end
        S_WR_HOLD: begin
          if (w_cnt_zero) r_we  <= 1'b0;
          else            r_cnt <= r_cnt - 4'd1;
        end
        S_WR_GAP: begin
          if (!w_idx_last) r_idx <= r_idx + 8'd1;
        end
        S_FIN: begin
          r_act  <= 1'b0;
          r_busy <= 1'b0;
          r_addr <= 8'd0;
          r_done <= !r_err;
        end
        default: ;
      endcase
    end
  end

  assign busy       = r_busy;
  assign done       = r_done;
  assign err        = r_err;
  assign sst_act    = r_act;
  assign sst_addr   = r_addr;
  assign sst_we_reg = r_we;
  assign sst_dato   = r_dato;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign in_ready   = (r_state == S_LD_WAIT);

endmodule
`default_nettype wire

// File: tb/tb_map_sst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_map_sst_seq
// Function : Self-checking bench for map_sst_seq with a small mapper model,
//            save-stream scoreboard and bus invariant monitor.
// Revision : 1.0 - initial release
// ============================================================================
module tb_map_sst_seq;

  localparam int REG_CNT = 6;
  localparam int ID_ADDR = 127;
  localparam int RD_WAIT = 1;
  localparam int WE_HOLD = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_save = 1'b0;
  logic       cmd_load = 1'b0;
  logic [7:0] map_idx_exp = 8'd75;
  logic       busy, done, err, sst_act, sst_we_reg, out_valid, in_ready;
  logic [7:0] sst_addr, sst_dato, sst_di, out_data;
  logic       out_ready = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       in_valid = 1'b0;

  int checks = 0;
  int errors = 0;

  map_sst_seq #(
    .REG_CNT(REG_CNT), .ID_ADDR(ID_ADDR), .RD_WAIT(RD_WAIT), .WE_HOLD(WE_HOLD)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cmd_save(cmd_save), .cmd_load(cmd_load),
    .map_idx_exp(map_idx_exp), .busy(busy), .done(done), .err(err),
    .sst_act(sst_act), .sst_addr(sst_addr), .sst_we_reg(sst_we_reg),
    .sst_dato(sst_dato), .sst_di(sst_di), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .in_data(in_data),
    .in_valid(in_valid), .in_ready(in_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // ---------------- mapper model ----------------
  logic [0:REG_CNT-1][7:0] m_regs;
  logic [0:REG_CNT-1][7:0] pre_regs;
  logic                    preload = 1'b0;
  int                      hold_cnt = 0;

  assign sst_di = (sst_addr == 8'(ID_ADDR)) ? 8'd75 :
                  (sst_addr < 8'(REG_CNT)) ? m_regs[sst_addr[2:0]] : 8'h00;

  // Register commits once the strobe has been held for the full hold time.
  always @(posedge clk) begin
    if (preload) begin
      m_regs   <= pre_regs;
      hold_cnt <= 0;
    end else if (sst_act && sst_we_reg) begin
      if (hold_cnt == WE_HOLD - 1 && sst_addr < 8'(REG_CNT)) m_regs[sst_addr[2:0]] <= sst_dato;
      hold_cnt <= hold_cnt + 1;
    end else begin
      hold_cnt <= 0;
    end
  end

  // ---------------- host out_ready driver ----------------
  logic stall = 1'b0;
  int   stall_cyc = 0;
  always @(posedge clk) begin
    #1;
    stall_cyc++;
    out_ready = stall ? (stall_cyc % 3 == 0) : 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  logic [7:0] sb[$];
  logic       saving = 1'b0;
  int         done_cnt = 0, viol = 0, writes = 0, bad_runs = 0, we_run = 0;
  logic       p_we = 1'b0, p_ov = 1'b0, p_or = 1'b0;
  logic [7:0] p_addr = 8'd0, p_dato = 8'd0, p_data = 8'd0;

  always @(negedge clk) begin
    if (!rst_n) begin
      we_run = 0;
      p_we   = 1'b0;
      p_ov   = 1'b0;
    end else begin
      if (done) done_cnt++;
      if (sst_we_reg && !sst_act) viol++;
      if (sst_we_reg && saving) viol++;
      if (in_ready && out_valid) viol++;
      if (p_we && sst_we_reg && (sst_addr != p_addr || sst_dato != p_dato)) viol++;
      if (p_ov && !p_or && (!out_valid || out_data != p_data)) viol++;
      if (sst_we_reg) we_run++;
      else if (we_run != 0) begin
        writes++;
        if (we_run != WE_HOLD) bad_runs++;
        we_run = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL save_extra: got byte %0h, expected no byte", out_data);
        end else begin
          check("save_byte", 64'(out_data), 64'(sb.pop_front()));
        end
      end
      p_we = sst_we_reg; p_addr = sst_addr; p_dato = sst_dato;
      p_ov = out_valid;  p_or = out_ready;  p_data = out_data;
    end
  end

  // ---------------- vector table ----------------
  typedef struct packed {
    logic                    is_load;
    logic                    stall;
    logic                    both;
    logic                    mid_load;
    logic                    preload;
    logic [7:0]              map_exp;
    int                      nbytes;
    logic [0:6][7:0]         stream;    // save: expected bytes, load: bytes sent
    logic [0:REG_CNT-1][7:0] init;
    logic                    exp_err;
    int                      exp_done;
    int                      exp_writes;
    logic [0:REG_CNT-1][7:0] exp_regs;
  } vec_t;

  vec_t tbl [0:5];

  task automatic send_byte(input logic [7:0] b, input string name);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL %s: got no in_ready within 200 cycles, expected handshake", name);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_preload(input logic [0:REG_CNT-1][7:0] vals);
    pre_regs = vals;
    preload  = 1'b1;
    @(posedge clk); #1;
    preload  = 1'b0;
  endtask

  task automatic run_case(input vec_t v, input int k);
    bit fin = 1'b0;
    if (v.preload) do_preload(v.init);
    done_cnt = 0; viol = 0; writes = 0; bad_runs = 0;
    saving      = !v.is_load;
    stall       = v.stall;
    map_idx_exp = v.map_exp;
    if (!v.is_load) for (int i = 0; i < 7; i++) sb.push_back(v.stream[i]);
    @(posedge clk); #1;
    cmd_save = !v.is_load;
    cmd_load = v.is_load | v.both;
    @(posedge clk); #1;
    cmd_save = 1'b0;
    cmd_load = 1'b0;
    if (v.is_load) begin
      for (int i = 0; i < v.nbytes; i++) send_byte(v.stream[i], $sformatf("case%0d_in%0d", k, i));
    end else if (v.mid_load) begin
      repeat (5) @(posedge clk);
      #1 cmd_load = 1'b1;
      @(posedge clk); #1 cmd_load = 1'b0;
    end
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      if (!busy) begin fin = 1'b1; break; end
    end
    if (!fin) begin
      checks++;
      errors++;
      $display("FAIL case%0d_timeout: got busy stuck high, expected completion", k);
    end
    repeat (2) @(negedge clk);
    check($sformatf("case%0d_err", k), 64'(err), 64'(v.exp_err));
    check($sformatf("case%0d_done", k), 64'(done_cnt), 64'(v.exp_done));
    check($sformatf("case%0d_writes", k), 64'(writes), 64'(v.exp_writes));
    check($sformatf("case%0d_we_len", k), 64'(bad_runs), 64'd0);
    check($sformatf("case%0d_inv", k), 64'(viol), 64'd0);
    check($sformatf("case%0d_sb_left", k), 64'(sb.size()), 64'd0);
    check($sformatf("case%0d_idle", k), {62'd0, busy, in_ready}, 64'd0);
    for (int i = 0; i < REG_CNT; i++)
      check($sformatf("case%0d_reg%0d", k, i), 64'(m_regs[i]), 64'(v.exp_regs[i]));
    sb.delete();
    saving = 1'b0;
    stall  = 1'b0;
  endtask

  initial begin
    tbl[0] = '{is_load:1'b0, stall:1'b0, both:1'b0, mid_load:1'b0, preload:1'b1, map_exp:8'd75, nbytes:7,
               stream:{8'h4B, 8'h03, 8'h05, 8'h09, 8'h11, 8'h1F, 8'h01},
               init:{8'h03, 8'h05, 8'h09, 8'h11, 8'h1F, 8'h01},
               exp_err:1'b0, exp_done:1, exp_writes:0,
               exp_regs:{8'h03, 8'h05, 8'h09, 8'h11, 8'h1F, 8'h01}};
    tbl[1] = tbl[0];
    tbl[1].stall   = 1'b1;
    tbl[1].preload = 1'b0;
    tbl[2] = '{is_load:1'b1, stall:1'b0, both:1'b0, mid_load:1'b0, preload:1'b0, map_exp:8'd75, nbytes:7,
               stream:{8'h4B, 8'h0A, 8'h0B, 8'h0C, 8'h1E, 8'h0F, 8'h01},
               init:'0, exp_err:1'b0, exp_done:1, exp_writes:6,
               exp_regs:{8'h0A, 8'h0B, 8'h0C, 8'h1E, 8'h0F, 8'h01}};
    tbl[3] = '{is_load:1'b1, stall:1'b0, both:1'b0, mid_load:1'b0, preload:1'b0, map_exp:8'd75, nbytes:1,
               stream:{8'h97, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55, 8'h55},
               init:'0, exp_err:1'b1, exp_done:0, exp_writes:0,
               exp_regs:{8'h0A, 8'h0B, 8'h0C, 8'h1E, 8'h0F, 8'h01}};
    tbl[4] = '{is_load:1'b0, stall:1'b0, both:1'b1, mid_load:1'b1, preload:1'b0, map_exp:8'd75, nbytes:7,
               stream:{8'h4B, 8'h0A, 8'h0B, 8'h0C, 8'h1E, 8'h0F, 8'h01},
               init:'0, exp_err:1'b0, exp_done:1, exp_writes:0,
               exp_regs:{8'h0A, 8'h0B, 8'h0C, 8'h1E, 8'h0F, 8'h01}};
    tbl[5] = '{is_load:1'b1, stall:1'b0, both:1'b0, mid_load:1'b0, preload:1'b0, map_exp:8'd75, nbytes:7,
               stream:{8'h4B, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26},
               init:'0, exp_err:1'b0, exp_done:1, exp_writes:6,
               exp_regs:{8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26}};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", {busy, done, err, sst_act, sst_we_reg, out_valid, in_ready,
                         sst_addr, sst_dato, out_data}, 64'd0);
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_case(tbl[k], k);

    // Reset asserted while the third register write strobe is high.
    do_preload({8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06});
    map_idx_exp = 8'd75;
    cmd_load = 1'b1;
    @(posedge clk); #1 cmd_load = 1'b0;
    send_byte(8'h4B, "rst_id");
    send_byte(8'h11, "rst_b0");
    send_byte(8'h22, "rst_b1");
    send_byte(8'h33, "rst_b2");
    begin
      bit seen = 1'b0;
      for (int c = 0; c < 50; c++) begin
        @(negedge clk);
        if (sst_we_reg && sst_addr == 8'd2) begin seen = 1'b1; break; end
      end
      check("rst_third_we_seen", 64'(seen), 64'd1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outs", {busy, done, err, sst_act, sst_we_reg, out_valid, in_ready,
                             sst_addr, sst_dato, out_data}, 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_reg0", 64'(m_regs[0]), 64'h11);
    check("rst_reg1", 64'(m_regs[1]), 64'h22);
    check("rst_reg2", 64'(m_regs[2]), 64'h03);
    rst_n = 1'b1;

    run_case(tbl[5], 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
